// File: rtl/stage1_if_mo.sv
// Instruction-fetch stage with up to MAX_OUTSTANDING requests in flight and an IBUF_DEPTH queue toward ID.
// Optional same-cycle response bypass to ID is enabled by defining IF_DATA_BYPASS_EN.
module stage1_if_mo #(
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4,
  parameter logic [31:0] RESET_PC        = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_taken,
  input  logic        br_stall,
  input  logic [31:0] br_target,
  input  logic        ds_allow_in,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  localparam int OW = 3;
  localparam int SW = 16;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(IBUF_DEPTH - 1)) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] discard_q, discard_d;
  logic          adef_lock_q, adef_lock_d;
  logic [CW-1:0] q_cnt_q, q_cnt_d;
  logic [PW-1:0] q_wp_q, q_wp_d, q_rp_q, q_rp_d;
  logic [PW-1:0] p_wp_q, p_wp_d, p_rp_q, p_rp_d;
  logic [64:0]   q_mem_q [IBUF_DEPTH];
  logic [31:0]   p_mem_q [IBUF_DEPTH];

  logic          redirect_s;
  logic [31:0]   redir_pc_s;
  logic [SW-1:0] live_s;
  logic          credit_s;
  logic          misalign_s;
  logic          adef_push_s;
  logic          hs_s;
  logic          drop_s;
  logic          live_rsp_s;
  logic          out_dec_s;
  logic [OW-1:0] outst_nx_s;
  logic          q_empty_s;
  logic          bypass_s;
  logic          q_pop_s;
  logic          q_push_s;
  logic [64:0]   q_wdata_s;
  logic [31:0]   p_head_s;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;
  assign inst_sram_addr  = fetch_pc_q;

  // Request credit, redirect decode and response classification
  always_comb begin
    redirect_s  = flush | (br_taken & ~br_stall);
    redir_pc_s  = flush ? flush_pc : br_target;
    live_s      = SW'(outst_q) - SW'(discard_q);
    // Credit reserves a queue slot for every live response before it is requested.
    credit_s    = ~reset & ~br_stall & ~adef_lock_q & ~flush & ~br_taken
                & (outst_q < OW'(MAX_OUTSTANDING))
                & ((live_s + SW'(q_cnt_q)) < SW'(IBUF_DEPTH));
    misalign_s  = fetch_pc_q[1:0] != 2'b00;
    inst_sram_req = credit_s & ~misalign_s;
    adef_push_s = credit_s & misalign_s & (live_s == {SW{1'b0}});
    hs_s        = inst_sram_req & inst_sram_addr_ok;
    drop_s      = inst_sram_data_ok & (discard_q != {OW{1'b0}});
    live_rsp_s  = inst_sram_data_ok & (discard_q == {OW{1'b0}});
    out_dec_s   = inst_sram_data_ok & (outst_q != {OW{1'b0}});
    outst_nx_s  = outst_q + OW'(hs_s) - OW'(out_dec_s);
    q_empty_s   = q_cnt_q == {CW{1'b0}};
    p_head_s    = p_mem_q[p_rp_q];
`ifdef IF_DATA_BYPASS_EN
    bypass_s    = q_empty_s & live_rsp_s & ~redirect_s;
`else
    bypass_s    = 1'b0;
`endif
    q_pop_s     = ~q_empty_s & ds_allow_in;
    q_push_s    = adef_push_s | (live_rsp_s & ~(bypass_s & ds_allow_in));
    if (adef_push_s) begin
      q_wdata_s = {1'b1, 32'h0000_0000, fetch_pc_q};
    end else begin
      q_wdata_s = {1'b0, inst_sram_rdata, p_head_s};
    end
  end

  // Head of queue (or bypassed response) toward ID
  always_comb begin
    fs_to_ds_valid = ~q_empty_s | bypass_s;
    if (!q_empty_s) begin
      fs_to_ds_bus = q_mem_q[q_rp_q];
    end else if (bypass_s) begin
      fs_to_ds_bus = {1'b0, inst_sram_rdata, p_head_s};
    end else begin
      fs_to_ds_bus = 65'h0;
    end
  end

  // Next-state for fetch PC, counters and queue pointers
  always_comb begin
    outst_d     = outst_nx_s;
    discard_d   = discard_q;
    fetch_pc_d  = fetch_pc_q;
    adef_lock_d = adef_lock_q;
    q_cnt_d     = q_cnt_q;
    q_wp_d      = q_wp_q;
    q_rp_d      = q_rp_q;
    p_wp_d      = p_wp_q;
    p_rp_d      = p_rp_q;
    if (redirect_s) begin
      // Every request still unanswered after this cycle belongs to the old path.
      discard_d   = outst_nx_s;
      fetch_pc_d  = redir_pc_s;
      adef_lock_d = 1'b0;
      q_cnt_d     = {CW{1'b0}};
      q_wp_d      = {PW{1'b0}};
      q_rp_d      = {PW{1'b0}};
      p_wp_d      = {PW{1'b0}};
      p_rp_d      = {PW{1'b0}};
    end else begin
      if (drop_s) begin
        discard_d = discard_q - OW'(1);
      end else begin
        discard_d = discard_q;
      end
      if (hs_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        p_wp_d     = ptr_inc(p_wp_q);
      end else begin
        fetch_pc_d = fetch_pc_q;
        p_wp_d     = p_wp_q;
      end
      if (adef_push_s) begin
        adef_lock_d = 1'b1;
      end else begin
        adef_lock_d = adef_lock_q;
      end
      if (live_rsp_s) begin
        p_rp_d = ptr_inc(p_rp_q);
      end else begin
        p_rp_d = p_rp_q;
      end
      if (q_push_s) begin
        q_wp_d = ptr_inc(q_wp_q);
      end else begin
        q_wp_d = q_wp_q;
      end
      if (q_pop_s) begin
        q_rp_d = ptr_inc(q_rp_q);
      end else begin
        q_rp_d = q_rp_q;
      end
      q_cnt_d = q_cnt_q + CW'(q_push_s) - CW'(q_pop_s);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      outst_q     <= {OW{1'b0}};
      discard_q   <= {OW{1'b0}};
      adef_lock_q <= 1'b0;
      q_cnt_q     <= {CW{1'b0}};
      q_wp_q      <= {PW{1'b0}};
      q_rp_q      <= {PW{1'b0}};
      p_wp_q      <= {PW{1'b0}};
      p_rp_q      <= {PW{1'b0}};
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      adef_lock_q <= adef_lock_d;
      q_cnt_q     <= q_cnt_d;
      q_wp_q      <= q_wp_d;
      q_rp_q      <= q_rp_d;
      p_wp_q      <= p_wp_d;
      p_rp_q      <= p_rp_d;
    end
  end

  // Instruction queue and pending-PC storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        q_mem_q[i] <= 65'h0;
        p_mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      if (!redirect_s && q_push_s) begin
        q_mem_q[q_wp_q] <= q_wdata_s;
      end
      if (hs_s) begin
        p_mem_q[p_wp_q] <= fetch_pc_q;
      end
    end
  end

  stage1_if_mo_chk #(
    .DEPTH (IBUF_DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk    (clk),
    .reset  (reset),
    .push_i (q_push_s & ~redirect_s),
    .pop_i  (q_pop_s & ~redirect_s),
    .cnt_i  (q_cnt_q)
  );

endmodule

// Queue overflow checker: a push into a full queue without a same-cycle pop must never happen.
module stage1_if_mo_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          push_i,
  input logic          pop_i,
  input logic [CW-1:0] cnt_i
);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (push_i && !pop_i) |-> (cnt_i != CW'(DEPTH)));

endmodule

// File: tb/tb_stage1_if_mo.sv
// Directed bench for stage1_if_mo: in-order fetch, backpressure, flush discard counting, branch/ADEF and latency.
module tb_stage1_if_mo;

  localparam logic [31:0] KEY = 32'h5A5A_0F0F;
`ifdef IF_DATA_BYPASS_EN
  localparam int EXP_LAT = 0;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] flush_pc;
  logic        br_taken;
  logic        br_stall;
  logic [31:0] br_target;
  logic        ds_allow_in;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  stage1_if_mo dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .br_taken          (br_taken),
    .br_stall          (br_stall),
    .br_target         (br_target),
    .ds_allow_in       (ds_allow_in),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          out_cnt = 0;
  int          max_out = 0;
  int          cyc_n = 0;
  int          first_dok = -1;
  int          first_vld = -1;
  int          n0;
  logic        mem_hold = 1'b0;
  logic [31:0] mem_q[$];
  logic [31:0] iss_addr[$];
  int          iss_cyc[$];
  logic [64:0] got_q[$];
  logic [31:0] tmp_addr;

  function automatic logic [64:0] ent(input logic [31:0] pc);
    ent = {1'b0, pc ^ KEY, pc};
  endfunction

  function automatic logic [64:0] got(input int i);
    if (i < got_q.size()) got = got_q[i];
    else got = {65{1'b1}};
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory answers the oldest accepted request, then outputs are sampled at negedge.
  task automatic cyc();
    cyc_n++;
    if (!mem_hold && mem_q.size() != 0) begin
      tmp_addr = mem_q.pop_front();
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = tmp_addr ^ KEY;
      out_cnt--;
      if (first_dok < 0) first_dok = cyc_n;
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
    end
    @(negedge clk);
    if (inst_sram_req && inst_sram_addr_ok) begin
      mem_q.push_back(inst_sram_addr);
      iss_addr.push_back(inst_sram_addr);
      iss_cyc.push_back(cyc_n);
      out_cnt++;
      if (out_cnt > max_out) max_out = out_cnt;
    end
    if (fs_to_ds_valid) begin
      if (first_vld < 0) first_vld = cyc_n;
      if (ds_allow_in) got_q.push_back(fs_to_ds_bus);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic done;
    br_stall = 1'b1;
    ds_allow_in = 1'b1;
    mem_hold = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (mem_q.size() == 0 && !fs_to_ds_valid) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_done", {64'd0, done}, 65'd1);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    flush_pc = 32'h0;
    br_taken = 1'b0;
    br_stall = 1'b0;
    br_target = 32'h0;
    ds_allow_in = 1'b0;
    inst_sram_addr_ok = 1'b1;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {64'd0, fs_to_ds_valid}, 65'd0);
    check("rst_req", {64'd0, inst_sram_req}, 65'd0);
    check("rst_bus", fs_to_ds_bus, 65'd0);
    check("rst_addr", {33'd0, inst_sram_addr}, {33'd0, 32'h1C00_0000});
    check("tie_size", {63'd0, inst_sram_size}, 65'd2);

    // In-order streaming fetch
    reset = 1'b0;
    ds_allow_in = 1'b1;
    repeat (8) cyc();
    check("t1_a0", {33'd0, iss_addr[0]}, {33'd0, 32'h1C00_0000});
    check("t1_a1", {33'd0, iss_addr[1]}, {33'd0, 32'h1C00_0004});
    check("t1_a2", {33'd0, iss_addr[2]}, {33'd0, 32'h1C00_0008});
    check("t1_b2b1", 65'(iss_cyc[1] - iss_cyc[0]), 65'd1);
    check("t1_b2b2", 65'(iss_cyc[2] - iss_cyc[0]), 65'd2);
    check("t1_latency", 65'(first_vld - first_dok), 65'(EXP_LAT));

    // Backpressure: queue fills, requests stop
    ds_allow_in = 1'b0;
    repeat (20) cyc();
    check("t2_req_off", {64'd0, inst_sram_req}, 65'd0);
    check("t2_valid", {64'd0, fs_to_ds_valid}, 65'd1);
    check("t2_qcount", 65'(iss_addr.size() - got_q.size()), 65'd4);
    check("t2_outst", 65'(out_cnt), 65'd0);
    ds_allow_in = 1'b1;
    repeat (4) cyc();
    drain();
    check("t2_count", 65'(got_q.size()), 65'(iss_addr.size()));
    for (int i = 0; i < got_q.size(); i++) begin
      check("t2_entry", got_q[i], ent(32'h1C00_0000 + 32'(4 * i)));
    end
    check("t2_maxout", {64'd0, max_out <= 2}, 65'd1);

    // Flush with two outstanding: both stale responses dropped
    got_q.delete();
    mem_hold = 1'b1;
    br_stall = 1'b0;
    repeat (3) cyc();
    check("t3_outst", 65'(out_cnt), 65'd2);
    check("t3_req_cap", {64'd0, inst_sram_req}, 65'd0);
    flush = 1'b1;
    flush_pc = 32'h1C00_0100;
    cyc();
    flush = 1'b0;
    mem_hold = 1'b0;
    repeat (6) cyc();
    drain();
    check("t3_first", got(0), ent(32'h1C00_0100));
    check("t3_second", got(1), ent(32'h1C00_0104));

    // Flush with a live data_ok in the same cycle: only one later drop
    got_q.delete();
    mem_hold = 1'b1;
    br_stall = 1'b0;
    repeat (3) cyc();
    check("t4_outst", 65'(out_cnt), 65'd2);
    mem_hold = 1'b0;
    flush = 1'b1;
    flush_pc = 32'h1C00_0200;
    cyc();
    mem_hold = 1'b1;
    flush = 1'b0;
    cyc();
    mem_hold = 1'b0;
    repeat (4) cyc();
    drain();
    check("t4_first", got(0), ent(32'h1C00_0200));
    check("t4_second", got(1), ent(32'h1C00_0204));

    // Stalled branch, then misaligned target: one ADEF entry and no bus request
    got_q.delete();
    n0 = iss_addr.size();
    br_taken = 1'b1;
    br_target = 32'h1C00_0042;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t5_stall_req", {64'd0, inst_sram_req}, 65'd0);
    end
    br_stall = 1'b0;
    cyc();
    br_taken = 1'b0;
    repeat (7) cyc();
    check("t5_lock_req", {64'd0, inst_sram_req}, 65'd0);
    check("t5_no_bus", 65'(iss_addr.size() - n0), 65'd0);
    check("t5_count", 65'(got_q.size()), 65'd1);
    check("t5_adef", got(0), {1'b1, 32'h0, 32'h1C00_0042});
    flush = 1'b1;
    flush_pc = 32'h1C00_0300;
    cyc();
    flush = 1'b0;
    #1;
    check("t5_unlock_req", {64'd0, inst_sram_req}, 65'd1);
    check("t5_unlock_addr", {33'd0, inst_sram_addr}, {33'd0, 32'h1C00_0300});

    // Reset mid-operation
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {64'd0, fs_to_ds_valid}, 65'd0);
    check("mid_rst_req", {64'd0, inst_sram_req}, 65'd0);
    check("mid_rst_bus", fs_to_ds_bus, 65'd0);
    check("mid_rst_addr", {33'd0, inst_sram_addr}, {33'd0, 32'h1C00_0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
